gpu_rect_copy: RTL and testbench



---
 rtl/gpu_rect_copy_pkg.sv | 34 +++
 rtl/gpu_copy_timeout.sv | 39 +++
 rtl/gpu_rect_copy.sv | 192 +++++++++++++++++++
 tb/tb_gpu_rect_copy.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_rect_copy_pkg.sv
// -----------------------------------------------------------------------------
// gpu_rect_copy_pkg
//
// Shared definitions for the GPU rectangle-table copy engine:
//   - copy_state_t      : copy FSM state encoding
//   - WORDS_PER_RECT    : words per rect record (x, y, width, height, color)
//   - words_total()     : total table length in words for a given rect-count
//                         width (N = 2**width rects)
//   - DEFAULT_ADDR_WIDTH, DEFAULT_BASE_ADDR : common data-memory constants
//                         used as parameter defaults by the copy engine
// -----------------------------------------------------------------------------
package gpu_rect_copy_pkg;

  // Common data-memory constants.
  localparam int          DEFAULT_ADDR_WIDTH = 13;
  localparam logic [12:0] DEFAULT_BASE_ADDR  = 13'h1000;

  // One rect record is x, y, width, height, color.
  localparam int WORDS_PER_RECT = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_STREAM,
    S_WAIT,
    S_DONE
  } copy_state_t;

  // Table length in words for 2**rect_count_width rects.
  function automatic int words_total(input int rect_count_width);
    return WORDS_PER_RECT * (1 << rect_count_width);
  endfunction

endpackage

// File: rtl/gpu_copy_timeout.sv
// -----------------------------------------------------------------------------
// gpu_copy_timeout
//
// Saturating grant-wait counter. Only instantiated by gpu_rect_copy when
// GPU_COPY_GNT_TIMEOUT_EN is defined.
//
// The counter is held at zero while run is low, so it starts from zero on
// every entry into the request state. While run is high it counts up once per
// cycle and saturates at all-ones; expired is high exactly while the count is
// all-ones.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   run      in   count enable (high while the copy engine is requesting)
//   expired  out  count has reached all-ones
// -----------------------------------------------------------------------------
module gpu_copy_timeout #(
  parameter int WIDTH = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = &count;

endmodule

// File: rtl/gpu_rect_copy.sv
// -----------------------------------------------------------------------------
// gpu_rect_copy
//
// Upstream feeder for the GPU rectangle receiver. On a frame trigger it
// requests the CPU data-memory read port, and once granted streams the rect
// table as a gap-free run of word addresses starting at BASE_ADDR
// (WORDS_PER_RECT words per rect, 2**RECT_COUNT_WIDTH rects). The receiver is
// held in reset whenever no copy is running, so its free-running field FSM is
// always phase-aligned with the returning read data: the receiver sits in its
// start state in the first stream cycle and sees the data for BASE_ADDR one
// cycle later (1-cycle synchronous memory read latency).
//
// Optional feature (macro GPU_COPY_GNT_TIMEOUT_EN):
//   When defined, a GNT_TIMEOUT_WIDTH-bit counter (gpu_copy_timeout) runs while
//   requesting; if it reaches all-ones with no grant the request is dropped,
//   frame_dropped pulses and the engine returns to idle. When undefined, the
//   request waits for the grant indefinitely and neither the counter nor the
//   GNT_TIMEOUT_WIDTH parameter exists.
//
// Parameters:
//   ADDR_WIDTH         data-memory word-address width
//   RECT_COUNT_WIDTH   log2 of the rect count
//   BASE_ADDR          word address of rect 0, field x
//   GNT_TIMEOUT_WIDTH  grant-wait counter width (only with the macro)
//
// Ports (all outputs registered):
//   clk            in   system clock
//   reset          in   synchronous, active-high
//   frame_start    in   one-cycle pulse requesting a table copy
//   copy_gnt       in   memory-port grant from the CPU arbiter, level
//   rx_finish      in   receiver finish pulse (last color word consumed)
//   copy_req       out  memory-port request, level
//   mem_addr       out  read address to data memory
//   rx_reset       out  receiver reset, active-high
//   busy           out  high in every state except idle
//   copy_done      out  pulse: table copied and finish seen
//   copy_error     out  pulse: grant lost mid-copy or finish missing
//   frame_dropped  out  pulse: frame_start ignored (or grant wait timed out)
// -----------------------------------------------------------------------------
module gpu_rect_copy
  import gpu_rect_copy_pkg::*;
#(
  parameter int                    ADDR_WIDTH       = DEFAULT_ADDR_WIDTH,
  parameter int                    RECT_COUNT_WIDTH = 6,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = ADDR_WIDTH'(DEFAULT_BASE_ADDR)
`ifdef GPU_COPY_GNT_TIMEOUT_EN
  , parameter int                  GNT_TIMEOUT_WIDTH = 10
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  copy_gnt,
  input  logic                  rx_finish,
  output logic                  copy_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  rx_reset,
  output logic                  busy,
  output logic                  copy_done,
  output logic                  copy_error,
  output logic                  frame_dropped
);

  // Word counter has 3 spare bits over the rect index, enough for 5 words
  // per rect.
  localparam int                CNT_W     = RECT_COUNT_WIDTH + 3;
  localparam int                W         = words_total(RECT_COUNT_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(W - 1);

  copy_state_t      state;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] word_cnt_inc;

  assign word_cnt_inc = word_cnt + 1'b1;

`ifdef GPU_COPY_GNT_TIMEOUT_EN
  logic gnt_expired;

  // Counter is held clear outside REQ, so it restarts on every REQ entry.
  gpu_copy_timeout #(
    .WIDTH (GNT_TIMEOUT_WIDTH)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .run     (state == S_REQ),
    .expired (gnt_expired)
  );
`endif

  // NOTE: all state and outputs live in one clocked block using non-blocking
  // assignments, so every output is a flop and reads of state/word_cnt below
  // always see the value from the start of the cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      copy_req      <= 1'b0;
      rx_reset      <= 1'b1;
      mem_addr      <= BASE_ADDR;
      word_cnt      <= '0;
      busy          <= 1'b0;
      copy_done     <= 1'b0;
      copy_error    <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      // NOTE: pulse outputs get their default at the top of the block; a later
      // assignment in the case below overrides it for that cycle only.
      copy_done     <= 1'b0;
      copy_error    <= 1'b0;
      frame_dropped <= frame_start && (state != S_IDLE);

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state    <= S_REQ;
            copy_req <= 1'b1;
            busy     <= 1'b1;
          end
        end

        S_REQ: begin
          if (copy_gnt) begin
            // Receiver leaves reset together with the first address so it is
            // in its start state at k=0 and in field x when data returns.
            state    <= S_STREAM;
            rx_reset <= 1'b0;
            word_cnt <= '0;
            mem_addr <= BASE_ADDR;
          end
`ifdef GPU_COPY_GNT_TIMEOUT_EN
          else if (gnt_expired) begin
            state         <= S_IDLE;
            copy_req      <= 1'b0;
            busy          <= 1'b0;
            frame_dropped <= 1'b1;
          end
`endif
        end

        S_STREAM: begin
          if (!copy_gnt) begin
            state      <= S_IDLE;
            copy_req   <= 1'b0;
            rx_reset   <= 1'b1;
            busy       <= 1'b0;
            copy_error <= 1'b1;
          end else if (word_cnt != LAST_WORD) begin
            word_cnt <= word_cnt_inc;
            // Address arithmetic wraps modulo 2**ADDR_WIDTH.
            mem_addr <= BASE_ADDR + ADDR_WIDTH'(word_cnt_inc);
          end else begin
            // mem_addr holds the last table address through WAIT.
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (!copy_gnt) begin
            state      <= S_IDLE;
            copy_req   <= 1'b0;
            rx_reset   <= 1'b1;
            busy       <= 1'b0;
            copy_error <= 1'b1;
          end else if (rx_finish) begin
            state     <= S_DONE;
            copy_req  <= 1'b0;
            rx_reset  <= 1'b1;
            copy_done <= 1'b1;
          end else begin
            state      <= S_IDLE;
            copy_req   <= 1'b0;
            rx_reset   <= 1'b1;
            busy       <= 1'b0;
            copy_error <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          copy_req <= 1'b0;
          rx_reset <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_rect_copy.sv
// -----------------------------------------------------------------------------
// tb_gpu_rect_copy
//
// Bench for gpu_rect_copy with RECT_COUNT_WIDTH=2 (4 rects, 20 words) and
// BASE_ADDR=0x100. A data-memory model (1-cycle read latency) and a receiver
// model (start, x, y, w, h, color...) surround the DUT. Expected address beats
// and expected pulses are queued with their cycle numbers when each scenario
// starts; a monitor pops and compares whenever the DUT shows a beat
// (rx_reset low) or a pulse.
// -----------------------------------------------------------------------------
module tb_gpu_rect_copy;
  import gpu_rect_copy_pkg::*;

  localparam int              AW   = 13;
  localparam int              RCW  = 2;
  localparam int              NR   = 4;
  localparam int              W    = 20;
  localparam logic [AW-1:0]   BASE = 13'h0100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          copy_gnt = 1'b0;
  logic          rx_finish;
  logic          copy_req;
  logic [AW-1:0] mem_addr;
  logic          rx_reset;
  logic          busy;
  logic          copy_done;
  logic          copy_error;
  logic          frame_dropped;

  gpu_rect_copy #(
    .ADDR_WIDTH       (AW),
    .RECT_COUNT_WIDTH (RCW),
    .BASE_ADDR        (BASE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .copy_gnt      (copy_gnt),
    .rx_finish     (rx_finish),
    .copy_req      (copy_req),
    .mem_addr      (mem_addr),
    .rx_reset      (rx_reset),
    .busy          (busy),
    .copy_done     (copy_done),
    .copy_error    (copy_error),
    .frame_dropped (frame_dropped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory and receiver models ----------------
  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    return {3'b101, a} ^ 16'h3C3C;
  endfunction

  logic [15:0] rdata;
  always @(posedge clk) rdata <= mem_word(mem_addr);

  int          rx_field = 0;
  int          rx_rect = 0;
  logic        suppress_finish = 1'b0;
  logic [15:0] cap [NR][5];

  always @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NR; r++)
        for (int f = 0; f < 5; f++) cap[r][f] <= '0;
    end
    if (rx_reset) begin
      rx_field <= 0;
      rx_rect  <= 0;
    end else begin
      if (rx_field != 0 && rx_rect < NR) cap[rx_rect][rx_field-1] <= rdata;
      if (rx_field == 5) begin
        rx_field <= 1;
        rx_rect  <= rx_rect + 1;
      end else begin
        rx_field <= rx_field + 1;
      end
    end
  end

  assign rx_finish = !rx_reset && (rx_field == 5) && (rx_rect == NR - 1) && !suppress_finish;

  // ---------------- scoreboard ----------------
  typedef enum int {EV_DONE, EV_ERROR, EV_DROP} ev_kind_e;
  typedef struct { ev_kind_e kind; int cyc; } ev_t;
  typedef struct { int cyc; logic [AW-1:0] addr; } beat_t;

  ev_t   ev_q[$];
  beat_t beat_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_event(input ev_kind_e k, input int now);
    ev_t e;
    check("event_expected", int'(ev_q.size() > 0), 1);
    if (ev_q.size() > 0) begin
      e = ev_q.pop_front();
      check("event_kind", int'(k), int'(e.kind));
      check("event_cycle", now, e.cyc);
    end
  endtask

  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rx_reset === 1'b0) begin
        check("beat_expected", int'(beat_q.size() > 0), 1);
        if (beat_q.size() > 0) begin
          b = beat_q.pop_front();
          check("beat_addr", int'(mem_addr), int'(b.addr));
          check("beat_cycle", cyc, b.cyc);
        end
      end
      if (copy_done === 1'b1)     pop_event(EV_DONE, cyc);
      if (copy_error === 1'b1)    pop_event(EV_ERROR, cyc);
      if (frame_dropped === 1'b1) pop_event(EV_DROP, cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic goto_cycle(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    frame_start = 1'b0;
    copy_gnt = 1'b0;
    suppress_finish = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Beats for k = 0..n-1 starting at absolute cycle c0.
  task automatic push_beats(input int c0, input int n);
    for (int k = 0; k < n; k++) beat_q.push_back('{cyc: c0 + k, addr: BASE + AW'(k)});
  endtask

  task automatic push_event(input ev_kind_e k, input int c);
    ev_q.push_back('{kind: k, cyc: c});
  endtask

  task automatic check_rects();
    for (int r = 0; r < NR; r++)
      for (int f = 0; f < 5; f++)
        check($sformatf("rect%0d_field%0d", r, f), int'(cap[r][f]),
              int'(mem_word(BASE + AW'(5 * r + f))));
  endtask

  task automatic check_drained(input string name);
    check({name, "_beats_left"}, beat_q.size(), 0);
    check({name, "_events_left"}, ev_q.size(), 0);
    beat_q.delete();
    ev_q.delete();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int t0;

    // Reset values.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_copy_req", int'(copy_req), 0);
    check("rst_rx_reset", int'(rx_reset), 1);
    check("rst_mem_addr", int'(mem_addr), int'(BASE));
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'({copy_done, copy_error, frame_dropped}), 0);

    // Nominal copy with grant tied high.
    do_reset();
    copy_gnt = 1'b1;
    t0 = cyc;
    frame_start = 1'b1;
    push_beats(t0 + 2, W);
    beat_q.push_back('{cyc: t0 + 22, addr: BASE + AW'(W - 1)});
    push_event(EV_DONE, t0 + 23);
    goto_cycle(t0 + 1);
    frame_start = 1'b0;
    check("nom_req_c1", int'(copy_req), 1);
    check("nom_busy_c1", int'(busy), 1);
    check("nom_rxrst_c1", int'(rx_reset), 1);
    goto_cycle(t0 + 23);
    check("nom_req_done", int'(copy_req), 0);
    check("nom_rxrst_done", int'(rx_reset), 1);
    check("nom_busy_done", int'(busy), 1);
    goto_cycle(t0 + 24);
    check("nom_busy_idle", int'(busy), 0);
    goto_cycle(t0 + 30);
    check_rects();
    check_drained("nominal");

    // Delayed grant.
    do_reset();
    t0 = cyc;
    frame_start = 1'b1;
    push_beats(t0 + 11, W);
    beat_q.push_back('{cyc: t0 + 31, addr: BASE + AW'(W - 1)});
    push_event(EV_DONE, t0 + 32);
    goto_cycle(t0 + 1);
    frame_start = 1'b0;
    goto_cycle(t0 + 5);
    check("dly_req_wait", int'(copy_req), 1);
    check("dly_rxrst_wait", int'(rx_reset), 1);
    check("dly_busy_wait", int'(busy), 1);
    goto_cycle(t0 + 10);
    copy_gnt = 1'b1;
    goto_cycle(t0 + 40);
    check_drained("delayed");

    // Grant lost mid-stream.
    do_reset();
    copy_gnt = 1'b1;
    t0 = cyc;
    frame_start = 1'b1;
    push_beats(t0 + 2, 7);
    push_event(EV_ERROR, t0 + 9);
    goto_cycle(t0 + 1);
    frame_start = 1'b0;
    goto_cycle(t0 + 8);
    copy_gnt = 1'b0;
    goto_cycle(t0 + 9);
    check("lost_rxrst", int'(rx_reset), 1);
    check("lost_req", int'(copy_req), 0);
    check("lost_busy", int'(busy), 0);
    goto_cycle(t0 + 20);
    check_drained("gnt_lost");

    // frame_start while busy.
    do_reset();
    copy_gnt = 1'b1;
    t0 = cyc;
    frame_start = 1'b1;
    push_beats(t0 + 2, W);
    beat_q.push_back('{cyc: t0 + 22, addr: BASE + AW'(W - 1)});
    push_event(EV_DROP, t0 + 6);
    push_event(EV_DONE, t0 + 23);
    goto_cycle(t0 + 1);
    frame_start = 1'b0;
    goto_cycle(t0 + 5);
    frame_start = 1'b1;
    goto_cycle(t0 + 6);
    frame_start = 1'b0;
    goto_cycle(t0 + 35);
    check("coll_busy_end", int'(busy), 0);
    check_drained("collision");

    // Receiver never finishes.
    do_reset();
    copy_gnt = 1'b1;
    suppress_finish = 1'b1;
    t0 = cyc;
    frame_start = 1'b1;
    push_beats(t0 + 2, W);
    beat_q.push_back('{cyc: t0 + 22, addr: BASE + AW'(W - 1)});
    push_event(EV_ERROR, t0 + 23);
    goto_cycle(t0 + 1);
    frame_start = 1'b0;
    goto_cycle(t0 + 23);
    check("nofin_busy", int'(busy), 0);
    check("nofin_rxrst", int'(rx_reset), 1);
    goto_cycle(t0 + 30);
    suppress_finish = 1'b0;
    check_drained("no_finish");

    // Reset in the middle of the stream.
    do_reset();
    copy_gnt = 1'b1;
    t0 = cyc;
    frame_start = 1'b1;
    push_beats(t0 + 2, 11);
    goto_cycle(t0 + 1);
    frame_start = 1'b0;
    goto_cycle(t0 + 12);
    reset = 1'b1;
    goto_cycle(t0 + 13);
    check("mrst_rxrst", int'(rx_reset), 1);
    check("mrst_req", int'(copy_req), 0);
    check("mrst_addr", int'(mem_addr), int'(BASE));
    check("mrst_busy", int'(busy), 0);
    reset = 1'b0;
    goto_cycle(t0 + 20);
    check_drained("mid_reset");

    // Grant never arrives.
    do_reset();
    t0 = cyc;
    frame_start = 1'b1;
`ifdef GPU_COPY_GNT_TIMEOUT_EN
    push_event(EV_DROP, t0 + 1025);
`endif
    goto_cycle(t0 + 1);
    frame_start = 1'b0;
`ifdef GPU_COPY_GNT_TIMEOUT_EN
    goto_cycle(t0 + 1030);
    check("tmo_req", int'(copy_req), 0);
    check("tmo_busy", int'(busy), 0);
`else
    goto_cycle(t0 + 200);
    check("nogrant_req", int'(copy_req), 1);
    check("nogrant_busy", int'(busy), 1);
    check("nogrant_rxrst", int'(rx_reset), 1);
`endif
    check_drained("no_grant");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
